md_unit: RTL and testbench

- EX-stage multiply/divide unit of the five-stage MIPS pipeline; directly consumes the ID/EX register outputs (operands, decoded op).
- Owns the HI/LO registers.
- Models fixed multi-cycle latency for MULT/MULTU/DIV/DIVU with a busy flag; the hazard unit uses it to stall dependent instructions in ID.
- Supports immediate MTHI/MTLO writes and suppression of the start on exception/interrupt.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_calc.sv | 80 ++++++++
 rtl/md_unit.sv | 121 ++++++++++++
 tb/tb_md_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg
// Shared definitions for the EX-stage multiply/divide unit: the decoded
// operation encoding delivered by the ID/EX register, and the default
// busy latencies for the multiply and divide families.
package md_pkg;

  // Decoded md operation.
  // 7 is reserved and behaves like NONE.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for the operations that go through the multi-cycle busy sequence.
  function automatic logic mdIsLong(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc
// Purely combinational arithmetic core of the multiply/divide unit.
// Produces the full 64-bit {hi,lo} result for the selected operation.
// The sequencing and latency are handled by the instantiating unit.
//
// Ports:
//   i_op            decoded md operation
//   i_rs            first operand (multiplicand / dividend)
//   i_rt            second operand (multiplier / divisor)
//   o_result        {hi,lo}: product, or {remainder,quotient} for divides
//   o_div_by_zero   divide operation with a zero divisor
module md_calc
  import md_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [63:0] o_result,
  output logic        o_div_by_zero
);

  logic signed [63:0] w_sProd;
  logic        [63:0] w_uProd;
  logic signed [31:0] w_sQuot;
  logic signed [31:0] w_sRem;
  logic        [31:0] w_uQuot;
  logic        [31:0] w_uRem;
  logic               w_rtZero;
  logic               w_sOverflow;

  assign w_rtZero    = (i_rt == 32'd0);
  // -2^31 / -1 cannot be represented; the quotient wraps to -2^31 with a
  // zero remainder, so it is handled explicitly rather than left to the
  // simulator's or synthesiser's divider.
  assign w_sOverflow = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

  assign w_sProd = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_uProd = {32'd0, i_rs} * {32'd0, i_rt};

  // Both dividers are guarded against a zero divisor so no undefined
  // value ever reaches the pending registers.
  always_comb begin
    w_sQuot = '0;
    w_sRem  = '0;
    w_uQuot = '0;
    w_uRem  = '0;
    if (!w_rtZero) begin
      w_uQuot = i_rs / i_rt;
      w_uRem  = i_rs % i_rt;
      if (w_sOverflow) begin
        w_sQuot = 32'sh8000_0000;
        w_sRem  = '0;
      end else begin
        // Verilog signed / and % truncate toward zero and give the
        // remainder the dividend's sign, matching MIPS semantics.
        w_sQuot = $signed(i_rs) / $signed(i_rt);
        w_sRem  = $signed(i_rs) % $signed(i_rt);
      end
    end
  end

  always_comb begin
    o_result      = '0;
    o_div_by_zero = 1'b0;
    case (i_op)
      MD_MULT:  o_result = w_sProd;
      MD_MULTU: o_result = w_uProd;
      MD_DIV: begin
        o_result      = {w_sRem, w_sQuot};
        o_div_by_zero = w_rtZero;
      end
      MD_DIVU: begin
        o_result      = {w_uRem, w_uQuot};
        o_div_by_zero = w_rtZero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit
// EX-stage multiply/divide unit of the five-stage MIPS pipeline. Owns the
// HI/LO registers. MULT/MULTU/DIV/DIVU compute their result immediately
// into pending registers, then hold busy for a fixed number of cycles
// before committing to HI/LO; the hazard unit uses busy to stall
// dependants. MTHI/MTLO write HI/LO directly at the next edge.
//
// Ports:
//   clk     pipeline clock, rising edge
//   reset   asynchronous, active-low reset
//   start   EX holds a valid md instruction this cycle
//   op      decoded md operation (md_op_e encoding)
//   rs      forwarded first operand / MTHI-MTLO source
//   rt      forwarded second operand
//   cancel  exception/interrupt commit; suppresses the start this cycle
//   busy    multi-cycle operation in flight
//   hi, lo  architectural HI/LO registers
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  md_op_e        w_op;
  logic          w_accept;
  logic [63:0]   w_calcResult;
  logic          w_calcDbz;
  logic          w_isDiv;

  logic          r_busy;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pendHi;
  logic [31:0]   r_pendLo;
  logic          r_pendDbz;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  assign w_op     = md_op_e'(op);
  // A start arriving while busy is dropped; the hazard unit keeps that
  // from happening in practice.
  assign w_accept = start && !cancel && !r_busy;
  assign w_isDiv  = (w_op == MD_DIV) || (w_op == MD_DIVU);

  md_calc u_calc (
    .i_op          (w_op),
    .i_rs          (rs),
    .i_rt          (rt),
    .o_result      (w_calcResult),
    .o_div_by_zero (w_calcDbz)
  );

  // Busy flag and countdown. The counter is loaded with the full latency
  // at accept so that the commit edge is exactly N edges later; the edge
  // that sees count==1 is the commit edge and also drops busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_count <= '0;
    end else if (r_busy) begin
      if (r_count == CW'(1)) begin
        r_busy  <= 1'b0;
        r_count <= '0;
      end else begin
        r_count <= r_count - CW'(1);
      end
    end else if (w_accept && mdIsLong(w_op)) begin
      r_busy  <= 1'b1;
      r_count <= w_isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end
  end

  // Pending result, captured at accept and held until commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pendHi  <= '0;
      r_pendLo  <= '0;
      r_pendDbz <= 1'b0;
    end else if (w_accept && mdIsLong(w_op)) begin
      r_pendHi  <= w_calcResult[63:32];
      r_pendLo  <= w_calcResult[31:0];
      r_pendDbz <= w_calcDbz;
    end
  end

  // Architectural HI/LO. Commit and MTHI/MTLO can never coincide because
  // an accept needs busy low and a commit only happens while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_busy) begin
      if ((r_count == CW'(1)) && !r_pendDbz) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
    end else if (w_accept) begin
      if (w_op == MD_MTHI) r_hi <= rs;
      if (w_op == MD_MTLO) r_lo <= rs;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
// Self-checking bench for md_unit: a table of operations with their
// expected HI/LO and busy length, driven through a scoreboard queue, plus
// hand-written sequences for reset mid-operation, cancel, and a start
// arriving while busy.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expCycles;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expCycles;
  } vec_t;

  exp_t        sbQ[$];
  vec_t        vecs[14];
  logic [31:0] modelHi;
  logic [31:0] modelLo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs     (rs),
    .rt     (rt),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one single-cycle start, pushing the expected outcome when the
  // operation is supposed to produce one. Returns just after the accept edge.
  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic cnc, input bit expectResult,
                               input logic [31:0] eHi, input logic [31:0] eLo, input int eCycles);
    exp_t e;
    start  = 1'b1;
    op     = o;
    rs     = a;
    rt     = b;
    cancel = cnc;
    if (expectResult) begin
      e.name      = name;
      e.expHi     = eHi;
      e.expLo     = eLo;
      e.expCycles = eCycles;
      sbQ.push_back(e);
    end
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    op     = MD_NONE;
  endtask

  // Wait (bounded) for busy to drop, then pop and compare. priorCycles
  // counts busy cycles the caller already stepped through.
  task automatic checkOutput(input int priorCycles);
    exp_t e;
    int   cyc;
    bit   firstSeen;
    cyc       = priorCycles;
    firstSeen = 1'b0;
    while (busy === 1'b1 && cyc < 40) begin
      if (!firstSeen) begin
        checkVal("holdOldHi", hi, modelHi);
        checkVal("holdOldLo", lo, modelLo);
        firstSeen = 1'b1;
      end
      cyc++;
      tick();
    end
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboardEmpty: got 0 entries, expected 1");
      return;
    end
    e = sbQ.pop_front();
    checkVal({e.name, ".cycles"}, 32'(cyc), 32'(e.expCycles));
    checkVal({e.name, ".hi"}, hi, e.expHi);
    checkVal({e.name, ".lo"}, lo, e.expLo);
    modelHi = e.expHi;
    modelLo = e.expLo;
  endtask

  initial begin
    vecs[0]  = '{"mult",      MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{"multu",     MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{"divNeg",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"divu",      MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{"divOvf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{"mthi",      MD_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h80000000, 0};
    vecs[6]  = '{"mtlo",      MD_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
    vecs[7]  = '{"divZero",   MD_DIV,   32'd5,        32'd0,        32'h00001234, 32'h00005678, 10};
    vecs[8]  = '{"divNegDvs", MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{"multMin",   MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[10] = '{"multuMax",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[11] = '{"divuBig",   MD_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[12] = '{"opNone",    MD_NONE,  32'hAAAAAAAA, 32'd1,        32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[13] = '{"opRsvd",    MD_RSVD,  32'h55555555, 32'd1,        32'h0000000F, 32'h0FFFFFFF, 0};

    start   = 1'b0;
    op      = MD_NONE;
    rs      = '0;
    rt      = '0;
    cancel  = 1'b0;
    reset   = 1'b0;
    modelHi = '0;
    modelLo = '0;

    // Reset state.
    tick();
    tick();
    checkVal("resetBusy", {31'd0, busy}, 32'd0);
    checkVal("resetHi", hi, 32'd0);
    checkVal("resetLo", lo, 32'd0);
    #2 reset = 1'b1;
    tick();

    // Table-driven operations.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, 1'b1,
                    vecs[i].expHi, vecs[i].expLo, vecs[i].expCycles);
      checkOutput(0);
      tick();
    end

    // Cancelled MTLO leaves LO alone; the uncancelled one writes at once.
    applyStimulus("mtloCancel", MD_MTLO, 32'hDEADBEEF, 32'd0, 1'b1, 1'b1, modelHi, modelLo, 0);
    checkOutput(0);
    applyStimulus("mtloLive", MD_MTLO, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, modelHi, 32'hDEADBEEF, 0);
    checkVal("mtloNoBusy", {31'd0, busy}, 32'd0);
    checkOutput(0);

    // MULT started while a DIV is busy is ignored; a cancel pulse during
    // the DIV does not disturb it. 100/7 = 14 r 2.
    applyStimulus("divIgnore", MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14, 10);
    checkVal("divIgnoreHoldHi", hi, modelHi);
    for (int k = 0; k < 3; k++) begin
      checkVal("divIgnoreBusy", {31'd0, busy}, 32'd1);
      cancel = (k == 1);
      tick();
    end
    cancel = 1'b0;
    start  = 1'b1;
    op     = MD_MULT;
    rs     = 32'd5;
    rt     = 32'd5;
    tick();
    start  = 1'b0;
    op     = MD_NONE;
    checkOutput(4);
    for (int k = 0; k < 8; k++) tick();
    checkVal("ignoredMultBusy", {31'd0, busy}, 32'd0);
    checkVal("ignoredMultHi", hi, 32'd2);
    checkVal("ignoredMultLo", lo, 32'd14);

    // Reset two cycles into a MULT: everything clears at once and the
    // aborted product never lands.
    applyStimulus("multAbort", MD_MULT, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkVal("abortBusy", {31'd0, busy}, 32'd0);
    checkVal("abortHi", hi, 32'd0);
    checkVal("abortLo", lo, 32'd0);
    #3 reset = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    checkVal("abortLateBusy", {31'd0, busy}, 32'd0);
    checkVal("abortLateHi", hi, 32'd0);
    checkVal("abortLateLo", lo, 32'd0);
    checkVal("scoreboardDrained", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
